// File: rtl/mux_rr_arbiter.sv
//-----------------------------------------------------------------------------
// mux_rr_arbiter
//
// Four-channel round-robin arbiter feeding a registered 4:1 data mux.
// Up to four valid/ready request channels compete. One winner per cycle is
// accepted, and its word and 2-bit channel index are registered onto a single
// valid/ready output channel.
//
// Handshake: a word moves on a channel on every rising clk edge where that
// channel's valid and ready are both high. Ready never depends on the
// same-channel valid in a way that could form a loop across this block.
// Valid, once raised by this block on the output, holds with stable
// data/sel until out_ready is seen high.
//
// Optional feature:
//   MUX_RR_ARBITER_STICKY_EN  when defined, the last granted channel may win
//                             up to BURST_MAX consecutive grants before
//                             round-robin rotation resumes.
//
// Parameters:
//   W          data width of every channel
//   BURST_MAX  max consecutive grants to one channel in sticky mode (1..15)
//
// Ports:
//   clk        clock, rising edge
//   rst_n      active-low reset, asynchronous assert, synchronous release
//   in_valid   per-channel request valid
//   in_data0..3  per-channel payload
//   in_ready   per-channel accept, one-hot or zero
//   out_valid  output register holds a word
//   out_data   registered selected payload
//   out_sel    registered index of the channel that supplied out_data
//   out_ready  downstream accepts the output word this cycle
//-----------------------------------------------------------------------------
module mux_rr_arbiter #(
  parameter int W         = 4,
  parameter int BURST_MAX = 4
) (
  input  logic         clk,
  input  logic         rst_n,
  input  logic [3:0]   in_valid,
  input  logic [W-1:0] in_data0,
  input  logic [W-1:0] in_data1,
  input  logic [W-1:0] in_data2,
  input  logic [W-1:0] in_data3,
  output logic [3:0]   in_ready,
  output logic         out_valid,
  output logic [W-1:0] out_data,
  output logic [1:0]   out_sel,
  input  logic         out_ready
);

  // Reject out-of-range burst limits at elaboration time.
  if (BURST_MAX < 1 || BURST_MAX > 15) begin : g_bad_burst_max
    $error("mux_rr_arbiter: BURST_MAX must be in 1..15");
  end

  //---------------------------------------------------------------------------
  // Reset synchroniser: assertion is immediate, release is aligned to clk so
  // every state flop leaves reset on the same edge.
  //---------------------------------------------------------------------------
  logic [1:0] rst_sync;
  logic       rst_int_n;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      rst_sync <= 2'b00;
    end else begin
      rst_sync <= {rst_sync[0], 1'b1};
    end
  end

  assign rst_int_n = rst_sync[1];

  //---------------------------------------------------------------------------
  // Arbitration state and request decode
  //---------------------------------------------------------------------------
  logic [1:0]   last;       // most recently accepted channel
  logic [1:0]   rr_grant;   // round-robin winner
  logic [1:0]   grant;      // final winner after optional stickiness
  logic         any_valid;
  logic         load;       // output register may take a new value
  logic         take;       // a channel is accepted this cycle
  logic [W-1:0] sel_data;

  assign any_valid = |in_valid;
  assign load      = !out_valid || out_ready;
  // While the synchronised reset is still held, nothing may be accepted or
  // the word would be lost.
  assign take      = load && any_valid && rst_int_n;

  // Search from last+1 upward, wrapping; k = 4 wraps back onto last itself,
  // so a lone requester on channel 'last' is still served.
  always_comb begin
    logic       found;
    logic [1:0] idx;
    found    = 1'b0;
    idx      = 2'd0;
    rr_grant = last;
    for (int k = 1; k <= 4; k++) begin
      idx = last + k[1:0];
      if (!found && in_valid[idx]) begin
        found    = 1'b1;
        rr_grant = idx;
      end
    end
  end

`ifdef MUX_RR_ARBITER_STICKY_EN
  //---------------------------------------------------------------------------
  // Sticky bursts: burst_cnt counts extra grants already given to 'last'.
  // have_last keeps the reset value of last (3) from looking like a real
  // previous winner, so channel 0 still wins first after reset.
  //---------------------------------------------------------------------------
  logic [3:0] burst_cnt;
  logic       have_last;
  logic       stick;

  localparam logic [3:0] BURST_LIMIT = 4'(BURST_MAX - 1);

  assign stick = have_last && in_valid[last] && (burst_cnt < BURST_LIMIT);
  assign grant = stick ? last : rr_grant;

  always_ff @(posedge clk or negedge rst_int_n) begin
    if (!rst_int_n) begin
      burst_cnt <= 4'd0;
      have_last <= 1'b0;
    end else if (take) begin
      burst_cnt <= stick ? burst_cnt + 4'd1 : 4'd0;
      have_last <= 1'b1;
    end else if (!in_valid[last]) begin
      // The burst owner went idle; its burst is over.
      burst_cnt <= 4'd0;
    end
  end
`else
  assign grant = rr_grant;
`endif

  //---------------------------------------------------------------------------
  // Accept decode and data mux
  //---------------------------------------------------------------------------
  always_comb begin
    in_ready = 4'b0000;
    if (take) begin
      in_ready[grant] = 1'b1;
    end
  end

  always_comb begin
    sel_data = in_data0;
    case (grant)
      2'd0:    sel_data = in_data0;
      2'd1:    sel_data = in_data1;
      2'd2:    sel_data = in_data2;
      default: sel_data = in_data3;
    endcase
  end

  //---------------------------------------------------------------------------
  // Output register. Loads only when empty or draining; a stalled word keeps
  // its data and sel. An idle load cycle only clears valid.
  //---------------------------------------------------------------------------
  always_ff @(posedge clk or negedge rst_int_n) begin
    if (!rst_int_n) begin
      out_valid <= 1'b0;
      out_data  <= '0;
      out_sel   <= 2'd0;
      last      <= 2'd3;
    end else if (load) begin
      if (any_valid) begin
        out_valid <= 1'b1;
        out_data  <= sel_data;
        out_sel   <= grant;
        last      <= grant;
      end else begin
        out_valid <= 1'b0;
      end
    end
  end

endmodule

// File: tb/tb_mux_rr_arbiter.sv
module tb_mux_rr_arbiter;

  localparam int W  = 4;
  localparam int BP = 4;

  logic         clk = 1'b0;
  logic         rst_n;
  logic [3:0]   in_valid;
  logic [W-1:0] in_data0, in_data1, in_data2, in_data3;
  logic [3:0]   in_ready;
  logic         out_valid;
  logic [W-1:0] out_data;
  logic [1:0]   out_sel;
  logic         out_ready;

  int n_checks = 0;
  int n_fail   = 0;

  // Reference model state: what the output register should hold and who
  // was served last.
  bit           m_valid;
  logic [W-1:0] m_data;
  int           m_sel;
  int           m_last;
  int           m_cnt;
  bit           m_have;

  // Words accepted by the model, in order, awaiting the output.
  logic [W-1:0] exp_q[$];

  always #5 clk = ~clk;

  mux_rr_arbiter #(.W(W), .BURST_MAX(BP)) dut (
    .clk(clk), .rst_n(rst_n), .in_valid(in_valid),
    .in_data0(in_data0), .in_data1(in_data1), .in_data2(in_data2), .in_data3(in_data3),
    .in_ready(in_ready), .out_valid(out_valid), .out_data(out_data),
    .out_sel(out_sel), .out_ready(out_ready)
  );

  task automatic model_reset();
    m_valid = 0; m_data = '0; m_sel = 0; m_last = 3; m_cnt = 0; m_have = 0;
    exp_q.delete();
  endtask

  // One clock cycle: drive inputs after the falling edge, check the DUT
  // against the model, then advance the model across the rising edge.
  task automatic step(input logic [3:0] v, input logic [W-1:0] d0, d1, d2, d3,
                      input logic ordy);
    logic [W-1:0] d[4];
    logic [3:0]   exp_ready;
    bit           ld, found, stick;
    int           g, idx;
    @(negedge clk);
    in_valid = v; in_data0 = d0; in_data1 = d1; in_data2 = d2; in_data3 = d3;
    out_ready = ordy;
    d[0] = d0; d[1] = d1; d[2] = d2; d[3] = d3;
    #1;
    ld = !m_valid || ordy;
    g = m_last; found = 0; stick = 0;
    for (int k = 1; k <= 4; k++) begin
      idx = (m_last + k) % 4;
      if (!found && v[idx]) begin found = 1; g = idx; end
    end
`ifdef MUX_RR_ARBITER_STICKY_EN
    stick = m_have && v[m_last] && (m_cnt < BP - 1);
    if (stick) g = m_last;
`endif
    exp_ready = (ld && v != 4'b0) ? 4'(1 << g) : 4'b0;
    n_checks++;
    if (in_ready !== exp_ready) begin
      n_fail++;
      $display("FAIL in_ready t=%0t got=%b want=%b", $time, in_ready, exp_ready);
    end
    n_checks++;
    if (out_valid !== m_valid) begin
      n_fail++;
      $display("FAIL out_valid t=%0t got=%b want=%b", $time, out_valid, m_valid);
    end
    if (m_valid) begin
      n_checks++;
      if (out_data !== m_data || out_sel !== 2'(m_sel) || exp_q.size() == 0 ||
          exp_q[0] !== out_data) begin
        n_fail++;
        $display("FAIL out_word t=%0t got=%0d/sel%0d want=%0d/sel%0d", $time,
                 out_data, out_sel, m_data, m_sel);
      end
    end
    // Advance the model.
    if (ld && m_valid && exp_q.size() > 0) void'(exp_q.pop_front());
    if (ld && v != 4'b0) begin
      m_cnt = stick ? m_cnt + 1 : 0;
      m_have = 1;
    end else if (!v[m_last]) begin
      m_cnt = 0;
    end
    if (ld) begin
      if (v != 4'b0) begin
        m_valid = 1; m_data = d[g]; m_sel = g; m_last = g;
        exp_q.push_back(d[g]);
      end else begin
        m_valid = 0;
      end
    end
    @(posedge clk);
  endtask

  task automatic do_reset();
    @(negedge clk);
    rst_n = 1'b0;
    in_valid = 4'b0; out_ready = 1'b1;
    repeat (2) @(negedge clk);
    rst_n = 1'b1;
    model_reset();
    // Let the synchronised release settle with nothing requesting.
    repeat (3) step(4'b0, '0, '0, '0, '0, 1'b1);
  endtask

  task automatic test_reset();
    rst_n = 1'b0;
    in_valid = 4'b1111; out_ready = 1'b1;
    in_data0 = 1; in_data1 = 2; in_data2 = 3; in_data3 = 4;
    repeat (2) @(negedge clk);
    n_checks++;
    if (out_valid !== 1'b0 || out_data !== '0 || out_sel !== 2'd0 || in_ready !== 4'b0) begin
      n_fail++;
      $display("FAIL reset_state got v=%b d=%0d s=%0d r=%b want 0/0/0/0000",
               out_valid, out_data, out_sel, in_ready);
    end
    do_reset();
  endtask

  task automatic test_round_robin();
    logic [1:0] sels[$];
    int exp_sel[5] = '{0, 1, 2, 3, 0};
    do_reset();
    for (int i = 0; i < 6; i++) begin
      step(4'b1111, 4'd1, 4'd2, 4'd3, 4'd4, 1'b1);
      if (out_valid) sels.push_back(out_sel);
    end
    for (int i = 0; i < 5; i++) begin
      n_checks++;
      if (i >= sels.size() || sels[i] !== 2'(exp_sel[i])) begin
        n_fail++;
        $display("FAIL rr_order idx=%0d got=%0d want=%0d", i,
                 (i < sels.size()) ? sels[i] : 2'bx, exp_sel[i]);
      end
    end
  endtask

  task automatic test_alternate();
    do_reset();
    for (int i = 0; i < 5; i++) step(4'b1010, 4'd9, 4'd10, 4'd11, 4'd12, 1'b1);
  endtask

  task automatic test_stall();
    do_reset();
    repeat (3) step(4'b1111, 4'd1, 4'd3, 4'd5, 4'd7, 1'b1);
    repeat (3) step(4'b1111, 4'd1, 4'd3, 4'd5, 4'd7, 1'b0);
    @(negedge clk);
    n_checks++;
    if (out_data !== 4'd5 || out_sel !== 2'd2 || out_valid !== 1'b1) begin
      n_fail++;
      $display("FAIL stall_hold got=%0d/sel%0d want=5/sel2", out_data, out_sel);
    end
    repeat (3) step(4'b1111, 4'd1, 4'd3, 4'd5, 4'd7, 1'b1);
  endtask

  task automatic test_idle_gap();
    step(4'b1111, 4'd2, 4'd4, 4'd6, 4'd8, 1'b1);
    repeat (2) step(4'b0000, 4'd0, 4'd0, 4'd0, 4'd0, 1'b1);
    repeat (3) step(4'b0001, 4'd13, 4'd0, 4'd0, 4'd0, 1'b1);
    step(4'b0000, 4'd0, 4'd0, 4'd0, 4'd0, 1'b1);
  endtask

  task automatic test_async_reset();
    step(4'b1111, 4'd6, 4'd7, 4'd8, 4'd9, 1'b0);
    step(4'b1111, 4'd6, 4'd7, 4'd8, 4'd9, 1'b0);
    @(negedge clk);
    #2;
    rst_n = 1'b0;
    #1;
    n_checks++;
    if (out_valid !== 1'b0 || out_data !== '0 || out_sel !== 2'd0 || in_ready !== 4'b0) begin
      n_fail++;
      $display("FAIL async_reset got v=%b d=%0d s=%0d r=%b want 0/0/0/0000",
               out_valid, out_data, out_sel, in_ready);
    end
    repeat (2) @(negedge clk);
    rst_n = 1'b1;
    model_reset();
    repeat (3) step(4'b0, '0, '0, '0, '0, 1'b1);
    repeat (4) step(4'b1111, 4'd6, 4'd7, 4'd8, 4'd9, 1'b1);
  endtask

  task automatic test_random();
    logic [3:0] v;
    logic       r;
    for (int i = 0; i < 400; i++) begin
      v = 4'($urandom_range(0, 15));
      r = ($urandom_range(0, 3) != 0);
      step(v, 4'($urandom), 4'($urandom), 4'($urandom), 4'($urandom), r);
    end
  endtask

  initial begin
    model_reset();
    test_reset();
    test_round_robin();
    test_alternate();
    test_stall();
    test_idle_gap();
    test_async_reset();
    test_random();
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule

// File: doc/mux_rr_arbiter.md
# mux_rr_arbiter

Four-channel round-robin arbiter that drives the select of the 4:1 data multiplexer stage and registers the chosen word. It accepts up to four valid/ready request channels, picks one per cycle, and presents the chosen data and its 2-bit channel index on a single registered valid/ready output channel. It sits directly upstream of the consumer of multiplexed data.

## Interface
Parameters:
- W, default 4: data width of every channel.
- BURST_MAX, default 4: maximum consecutive grants to one channel. Used only when sticky mode is compiled in. Legal range 1..15.

Ports:
- clk  input  1  single clock, rising edge.
- rst_n  input  1  reset, asynchronous assert and active-low; internally released synchronously to clk.
- in_valid  input  4  bit i set means channel i offers in_data_i.
- in_data0, in_data1, in_data2, in_data3  input  W each  channel payloads.
- in_ready  output  4  one-hot or zero; bit i means channel i is accepted this cycle.
- out_valid  output  1  out_data and out_sel hold a word.
- out_data  output  W  registered selected payload.
- out_sel  output  2  registered index of the channel that supplied out_data.
- out_ready  input  1  downstream accepts the word this cycle.

## Operation
- A transfer on any channel occurs when valid and ready are both high in the same cycle.
- load = !out_valid || out_ready. The output register loads only on a cycle where load is high.
- grant: the first i with in_valid[i] set, searching from (last+1) mod 4 and wrapping. last is the index of the most recently accepted channel.
- in_ready[i] = load && (in_valid != 0) && (grant == i). At most one in_ready bit is high. in_ready is combinational from in_valid, out_valid and out_ready.
- On load with any in_valid set:
  - out_data <= the granted in_data;
  - out_sel <= grant;
  - out_valid <= 1;
  - last <= grant.
- On load with in_valid == 0: out_valid <= 0. out_data, out_sel and last keep their values.
- When load is low, all registers hold. A stalled output (out_valid=1, out_ready=0) keeps out_data and out_sel stable.
- Channels that are not granted are not consumed. The arbiter never drops or duplicates a word.
- Reset values:
  - out_valid = 0;
  - out_data = 0;
  - out_sel = 0;
  - last = 3, so channel 0 has first priority after reset;
  - burst counter = 0;
  - in_ready = 0 while rst_n is low.
- If reset asserts mid-operation, the word held in the output register is discarded. No partial state survives reset.

## Timing
- Latency: one cycle from input acceptance to the word appearing on out_valid/out_data.
- Throughput: one word per cycle while out_ready stays high.
- Back-to-back case, out_valid=1 and out_ready=1: the current word leaves and a new word loads in the same cycle.
- Fairness: with all four channels continuously valid and the sticky feature absent, the grant order is 0,1,2,3,0,... and each channel waits at most 3 accepted transfers.
- No combinational path from in_valid or in_data to out_*.

## Configuration
- Macro: MUX_RR_ARBITER_STICKY_EN.
- Defined (sticky mode):
  - If in_valid[last] is set and the burst counter is below BURST_MAX-1, channel last wins again and the counter increments.
  - Otherwise normal round-robin applies and the counter clears to 0 on the grant.
  - The counter also clears when last drops valid.
  - The counter is 4 bits wide.
- Undefined: strict round-robin on every transfer. The counter logic is absent and BURST_MAX is ignored.

## Test plan
- Reset, then in_valid=4'b1111 with in_data0..3 = 1,2,3,4 and out_ready=1 -> out_sel sequence 0,1,2,3,0 and out_data 1,2,3,4,1, starting one cycle after the first in_ready.
- in_valid=4'b1010, last=3 after reset, out_ready=1 -> grants 1,3,1,3; in_ready[0] and in_ready[2] never assert.
- A word with out_sel=2 and out_data=5 is held while out_ready=0 for 3 cycles with all inputs valid -> out_data and out_sel stay at 5 and 2, and in_ready stays 0 for those 3 cycles; it resumes with grant 3.
- in_valid drops to 0 with out_ready=1 -> out_valid=0 the next cycle; reasserting in_valid=4'b0001 -> out_sel=0 one cycle after acceptance.
- rst_n pulsed low while out_valid=1 -> out_valid, out_data and out_sel read 0 immediately (asynchronous); after release, first grant goes to channel 0.
- With MUX_RR_ARBITER_STICKY_EN defined, BURST_MAX=2, all channels valid -> grants 0,0,1,1,2,2,3,3.
